// File: rtl/max_seq_pkg.sv
// max_seq_pkg: shared types and constants for the max_seq_ctrl frame-maximum controller
package max_seq_pkg;
  typedef enum logic [2:0] {IDLE, FILL_A, FILL_B, CMP, DONE} state_t;
  localparam int DATA_W_DEF = 8;
  localparam logic [1:0] SEL_RUN = 2'd0;
  localparam logic [1:0] SEL_A = 2'd1;
  localparam logic [1:0] SEL_B = 2'd2;
endpackage

// File: rtl/max_seq_ctrl_max3.sv
// max3_cmp: combinational 3-input unsigned max, strict '>' so ties keep the earliest operand
// Ports: i_run/i_a/i_b operands in priority order; o_max winning value; o_sel winner (SEL_RUN/SEL_A/SEL_B)
module max3_cmp
  import max_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_run,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_max,
  output logic [1:0]        o_sel
);
  always_comb begin
    o_sel = (i_a > i_run) ? ((i_b > i_a) ? SEL_B : SEL_A) : ((i_b > i_run) ? SEL_B : SEL_RUN);
    o_max = (o_sel == SEL_A) ? i_a : (o_sel == SEL_B) ? i_b : i_run;
  end
endmodule

// File: rtl/max_seq_ctrl.sv
// max_seq_ctrl: finds the maximum of a FRAME_LEN-sample frame, folding sample pairs through one max3_cmp
// Ports: i_clk, i_rst_n (async active-low); i_start frame start pulse (IDLE only);
//   i_valid/o_ready/i_data sample stream; o_valid/i_ready/o_max frame result; o_busy high outside IDLE;
//   o_idx 0-based position of the maximum, present only when MAX_SEQ_IDX_EN is defined.
module max_seq_ctrl
  import max_seq_pkg::*;
#(
  parameter int  DATA_W    = DATA_W_DEF,
  parameter int  FRAME_LEN = 6,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_busy,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_max
`ifdef MAX_SEQ_IDX_EN
  ,
  output logic [CNT_W-1:0]  o_idx
`endif
);
  if (FRAME_LEN < 1) begin : g_bad_len
    $error("max_seq_ctrl: FRAME_LEN must be >= 1");
  end
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN);
  localparam bit ODD = (FRAME_LEN % 2) == 1;
  state_t r_state, w_state_nxt;
  logic [DATA_W-1:0] r_max, r_a, r_b, w_max;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [1:0] w_sel;
  logic w_hs_in, w_hs_out;
  assign w_hs_in = i_valid & o_ready;
  assign w_hs_out = o_valid & i_ready;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  max3_cmp #(.DATA_W(DATA_W)) u_cmp (
    .i_run(r_max),
    .i_a  (r_a),
    .i_b  (r_b),
    .o_max(w_max),
    .o_sel(w_sel)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = i_start ? FILL_A : IDLE;
      FILL_A:  w_state_nxt = !w_hs_in ? FILL_A : (w_cnt_nxt == LAST) ? CMP : FILL_B;
      FILL_B:  w_state_nxt = w_hs_in ? CMP : FILL_B;
      CMP:     w_state_nxt = (r_cnt == LAST) ? DONE : FILL_A;
      DONE:    w_state_nxt = w_hs_out ? IDLE : DONE;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_comb begin
    o_ready = (r_state == FILL_A) || (r_state == FILL_B);
    o_busy = r_state != IDLE;
    o_valid = r_state == DONE;
    o_max = r_max;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_max <= '0;
      r_a <= '0;
      r_b <= '0;
      r_cnt <= '0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_max <= '0;
        r_cnt <= '0;
      end
      if (r_state == FILL_A && w_hs_in) begin
        r_a <= i_data;
        r_cnt <= w_cnt_nxt;
        // last sample of an odd frame: pad b with 0, which can never win a strict compare
        if (w_cnt_nxt == LAST) r_b <= '0;
      end
      if (r_state == FILL_B && w_hs_in) begin
        r_b <= i_data;
        r_cnt <= w_cnt_nxt;
      end
      if (r_state == CMP && w_sel != SEL_RUN) r_max <= w_max;
    end
`ifdef MAX_SEQ_IDX_EN
  logic [CNT_W-1:0] r_idx, w_pos_a;
  // on the padded pass a holds the last sample, otherwise a is one before b
  assign w_pos_a = (ODD && r_cnt == LAST) ? r_cnt - CNT_W'(1) : r_cnt - CNT_W'(2);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_idx <= '0;
    else if (r_state == IDLE && i_start) r_idx <= '0;
    else if (r_state == CMP) r_idx <= (w_sel == SEL_A) ? w_pos_a : (w_sel == SEL_B) ? r_cnt - CNT_W'(1) : r_idx;
  assign o_idx = r_idx;
`endif
endmodule
